// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues operations and observes HI/LO.
    modport master (
        output start, op, data1, data2, cancel,
        input  busy, done, div_zero, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, data1, data2, cancel,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Signed operations run on magnitudes and
// apply the result signs in a final FIX cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             res_neg_q, res_neg_d;   // negate product / quotient
    logic             rem_neg_q, rem_neg_d;   // negate remainder (dividend sign)
    logic             dz_q, dz_d;             // in-flight divide has divisor 0
    logic [WIDTH-1:0] b_q, b_d;               // multiplicand or divisor magnitude
    logic [WIDTH:0]   acc_q, acc_d;           // product high half or partial remainder
    logic [WIDTH-1:0] q_q, q_d;               // multiplier / quotient shift register
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_out_q, dz_out_d;

    logic             d1_neg, d2_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // State register and all datapath flops, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_out_q  <= dz_out_d;
        end
    end

    // Next-state logic: accept mul/div only when idle; cancel aborts CALC or FIX.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start && !bus.op[2]) state_d = StCalc;
            StCalc: begin
                if (bus.cancel)            state_d = StIdle;
                else if (cnt_q == CntLast) state_d = StFix;
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic.
    always_comb begin
        bus.busy     = (state_q != StIdle);
        bus.done     = done_q;
        bus.div_zero = dz_out_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end

    // Datapath: operand capture, one radix-2 step per CALC edge, sign fix in FIX.
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        b_d       = b_q;
        acc_d     = acc_q;
        q_d       = q_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_out_d  = 1'b0;

        // op[0]=0 selects the signed variants.
        d1_neg = !bus.op[0] && bus.data1[WIDTH-1];
        d2_neg = !bus.op[0] && bus.data2[WIDTH-1];
        mag1   = d1_neg ? (~bus.data1 + 1'b1) : bus.data1;
        mag2   = d2_neg ? (~bus.data2 + 1'b1) : bus.data2;

        mul_sum   = {1'b0, acc_q[WIDTH-1:0]} + (q_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        prod      = {acc_q[WIDTH-1:0], q_q};
        prod_fix  = res_neg_q ? (~prod + 1'b1) : prod;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.op[2]) begin
                    is_div_d  = bus.op[1];
                    b_d       = bus.op[1] ? mag2 : mag1;
                    q_d       = bus.op[1] ? mag1 : mag2;
                    acc_d     = '0;
                    cnt_d     = '0;
                    dz_d      = bus.op[1] && (bus.data2 == '0);
                    // Divide by zero: the magnitude loop yields all-ones quotient and the
                    // dividend magnitude as remainder; skipping the quotient negate and
                    // re-applying the dividend sign returns data1 unchanged in HI.
                    res_neg_d = (d1_neg ^ d2_neg) && !(bus.op[1] && (bus.data2 == '0));
                    rem_neg_d = d1_neg;
                end else if (bus.start && bus.op == 3'b100) begin
                    hi_d = bus.data1;
                end else if (bus.start && bus.op == 3'b101) begin
                    lo_d = bus.data1;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (div_shift >= {1'b0, b_q}) begin
                        acc_d = div_shift - {1'b0, b_q};
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift;
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, mul_sum[WIDTH:1]};
                    q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
                end
            end
            StFix: begin
                if (!bus.cancel) begin
                    if (is_div_q) begin
                        lo_d = res_neg_q ? (~q_q + 1'b1) : q_q;
                        hi_d = rem_neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d   = 1'b1;
                    dz_out_d = dz_q;
                end
            end
            default: ;
        endcase
    end
endmodule
